// File: rtl/dmem_access_ctrl.sv
// rtl/dmem_access_ctrl.sv - memory-stage load/store sequencer for the data-memory bus
//
// Turns the load or store held in EX/MEM into one valid/ready bus transaction,
// stalls the pipeline until the response returns, formats store lanes/strobes,
// extends load data, suppresses misaligned accesses and aborts on bus timeout.
//
// Ports
//   clk, rst_n          pipeline clock, asynchronous active-low reset
//   mem_read_mem        load pending in EX/MEM
//   mem_write_mem       store pending in EX/MEM
//   alu_result_mem      effective byte address
//   rs2_data_mem        unformatted store data
//   mem_load_type_mem   000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU, 111 none
//   mem_store_type_mem  00 SB, 01 SH, 10 SW, 11 none
//   bus_req/bus_we/bus_addr/bus_wdata/bus_wstrb   request channel (valid + payload)
//   bus_ready           request accepted this cycle
//   bus_rsp_valid/bus_rdata                       response channel
//   stall_mem           freeze IF..EX/MEM pipeline registers
//   load_data           extended load result, valid with done
//   done                one-cycle completion pulse (ok or error)
//   misalign_exc        one-cycle pulse: misaligned access suppressed
//   bus_err             one-cycle pulse with done: timeout abort

module dmem_access_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read_mem,
    input  logic        mem_write_mem,
    input  logic [31:0] alu_result_mem,
    input  logic [31:0] rs2_data_mem,
    input  logic [2:0]  mem_load_type_mem,
    input  logic [1:0]  mem_store_type_mem,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_ready,
    input  logic        bus_rsp_valid,
    input  logic [31:0] bus_rdata,
    output logic        stall_mem,
    output logic [31:0] load_data,
    output logic        done,
    output logic        misalign_exc,
    output logic        bus_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [2:0] LT_LB  = 3'b000;
    localparam logic [2:0] LT_LH  = 3'b001;
    localparam logic [2:0] LT_LW  = 3'b010;
    localparam logic [2:0] LT_LBU = 3'b100;
    localparam logic [2:0] LT_LHU = 3'b101;
    localparam logic [1:0] ST_SB  = 2'b00;
    localparam logic [1:0] ST_SH  = 2'b01;
    localparam logic [1:0] ST_SW  = 2'b10;

    // Last cycle of the REQ+WAIT budget: the counter reads 0 on the first REQ cycle.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t      state, state_next;
    logic [7:0]  cnt;
    logic [2:0]  ltype_q;
    logic [1:0]  lo_q;
    logic        err_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  strb_q;
    logic        we_q;
    logic [31:0] load_q;

    // Access decode
    logic load_ok, store_ok, access, is_half, is_word, misaligned;

    always_comb begin
        load_ok = 1'b0;
        if (mem_read_mem) begin
            case (mem_load_type_mem)
                LT_LB, LT_LH, LT_LW, LT_LBU, LT_LHU: load_ok = 1'b1;
                default:                             load_ok = 1'b0;
            endcase
        end
    end

    assign store_ok   = mem_write_mem && (mem_store_type_mem != 2'b11);
    assign access     = load_ok || store_ok;
    assign is_half    = load_ok ? (mem_load_type_mem[1:0] == 2'b01) : (mem_store_type_mem == ST_SH);
    assign is_word    = load_ok ? (mem_load_type_mem == LT_LW)      : (mem_store_type_mem == ST_SW);
    assign misaligned = access && ((is_half && alu_result_mem[0]) ||
                                   (is_word && (alu_result_mem[1:0] != 2'b00)));

    // Store lane formatting; reads carry no data and no strobes.
    logic [31:0] fmt_wdata;
    logic [3:0]  fmt_strb;

    always_comb begin
        fmt_wdata = 32'h0;
        fmt_strb  = 4'b0000;
        if (store_ok) begin
            case (mem_store_type_mem)
                ST_SB: begin
                    fmt_wdata = {4{rs2_data_mem[7:0]}};
                    fmt_strb  = 4'b0001 << alu_result_mem[1:0];
                end
                ST_SH: begin
                    fmt_wdata = {2{rs2_data_mem[15:0]}};
                    fmt_strb  = 4'b0011 << alu_result_mem[1:0];
                end
                default: begin
                    fmt_wdata = rs2_data_mem;
                    fmt_strb  = 4'b1111;
                end
            endcase
        end
    end

    // Load extraction from the latched low address bits and load type.
    logic [31:0] rd_shift;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] ext_data;

    assign rd_shift = bus_rdata >> {lo_q, 3'b000};
    assign rd_byte  = rd_shift[7:0];
    assign rd_half  = lo_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];

    always_comb begin
        case (ltype_q)
            LT_LB:   ext_data = {{24{rd_byte[7]}}, rd_byte};
            LT_LH:   ext_data = {{16{rd_half[15]}}, rd_half};
            LT_LBU:  ext_data = {24'h0, rd_byte};
            LT_LHU:  ext_data = {16'h0, rd_half};
            default: ext_data = bus_rdata;
        endcase
    end

    logic timeout_hit;
    assign timeout_hit = (cnt == TMO_LAST);

    // Next-state logic
    logic accept, capture, abort;

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        capture    = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE: begin
                if (access && !misaligned) begin
                    accept     = 1'b1;
                    state_next = REQ;
                end
            end
            REQ: begin
                // Timeout wins over a same-cycle ready so the budget is never overrun.
                if (timeout_hit) begin
                    abort      = 1'b1;
                    state_next = DONE;
                end else if (bus_ready) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                // A response that arrives on the last budget cycle is still taken.
                if (bus_rsp_valid) begin
                    capture    = 1'b1;
                    state_next = DONE;
                end else if (timeout_hit) begin
                    abort      = 1'b1;
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= 8'h0;
            err_q   <= 1'b0;
            ltype_q <= 3'b111;
            lo_q    <= 2'b00;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            strb_q  <= 4'b0000;
            we_q    <= 1'b0;
            load_q  <= 32'h0;
        end else begin
            if (accept) begin
                cnt     <= 8'h0;
                err_q   <= 1'b0;
                ltype_q <= load_ok ? mem_load_type_mem : 3'b111;
                lo_q    <= alu_result_mem[1:0];
                addr_q  <= {alu_result_mem[31:2], 2'b00};
                wdata_q <= fmt_wdata;
                strb_q  <= fmt_strb;
                we_q    <= store_ok;
            end else if (state == REQ || state == WAIT) begin
                cnt <= cnt + 8'd1;
            end
            if (abort) begin
                err_q  <= 1'b1;
                load_q <= 32'h0;
            end else if (capture && !we_q) begin
                load_q <= ext_data;
            end
        end
    end

    // Outputs. The combinational stall/exception terms are gated by rst_n so
    // that every output reads zero while reset is held, even with an access present.
    assign bus_req      = (state == REQ);
    assign bus_we       = we_q;
    assign bus_addr     = addr_q;
    assign bus_wdata    = wdata_q;
    assign bus_wstrb    = strb_q;
    assign load_data    = load_q;
    assign done         = (state == DONE);
    assign bus_err      = (state == DONE) && err_q;
    assign misalign_exc = rst_n && (state == IDLE) && misaligned;
    assign stall_mem    = rst_n && ((state == REQ) || (state == WAIT) ||
                                    ((state == IDLE) && access && !misaligned));

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb/tb_dmem_access_ctrl.sv - scoreboard bench for dmem_access_ctrl

module tb_dmem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_read_mem, mem_write_mem;
    logic [31:0] alu_result_mem, rs2_data_mem;
    logic [2:0]  mem_load_type_mem;
    logic [1:0]  mem_store_type_mem;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_ready, bus_rsp_valid;
    logic [31:0] bus_rdata;
    logic        stall_mem;
    logic [31:0] load_data;
    logic        done, misalign_exc, bus_err;

    always #5 clk = ~clk;

    dmem_access_ctrl #(.TIMEOUT(4)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .mem_read_mem       (mem_read_mem),
        .mem_write_mem      (mem_write_mem),
        .alu_result_mem     (alu_result_mem),
        .rs2_data_mem       (rs2_data_mem),
        .mem_load_type_mem  (mem_load_type_mem),
        .mem_store_type_mem (mem_store_type_mem),
        .bus_req            (bus_req),
        .bus_we             (bus_we),
        .bus_addr           (bus_addr),
        .bus_wdata          (bus_wdata),
        .bus_wstrb          (bus_wstrb),
        .bus_ready          (bus_ready),
        .bus_rsp_valid      (bus_rsp_valid),
        .bus_rdata          (bus_rdata),
        .stall_mem          (stall_mem),
        .load_data          (load_data),
        .done               (done),
        .misalign_exc       (misalign_exc),
        .bus_err            (bus_err)
    );

    typedef struct {
        logic [31:0] load;
        logic        err;
        int          stall;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] last_load = 32'h0;
    int          vectors = 0;
    int          errors  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        mem_read_mem       = 1'b0;
        mem_write_mem      = 1'b0;
        alu_result_mem     = 32'h0;
        rs2_data_mem       = 32'h0;
        mem_load_type_mem  = 3'b111;
        mem_store_type_mem = 2'b11;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_bus_req"},   {31'h0, bus_req},      32'h0);
        chk({tag, "_bus_we"},    {31'h0, bus_we},       32'h0);
        chk({tag, "_bus_addr"},  bus_addr,              32'h0);
        chk({tag, "_bus_wdata"}, bus_wdata,             32'h0);
        chk({tag, "_bus_wstrb"}, {28'h0, bus_wstrb},    32'h0);
        chk({tag, "_load_data"}, load_data,             32'h0);
        chk({tag, "_done"},      {31'h0, done},         32'h0);
        chk({tag, "_misalign"},  {31'h0, misalign_exc}, 32'h0);
        chk({tag, "_bus_err"},   {31'h0, bus_err},      32'h0);
        chk({tag, "_stall"},     {31'h0, stall_mem},    32'h0);
    endtask

    // One aligned access: drives EX/MEM, plays the bus (ready after rdy_dly
    // REQ cycles, response on the first WAIT cycle), checks the request
    // payload every REQ cycle and the scoreboard entry on done.
    task automatic access(input string tag, input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [31:0] rs2,
                          input logic [2:0] lt, input logic [1:0] st,
                          input int rdy_dly, input logic early, input logic [31:0] rdata,
                          input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                          input logic [3:0] exp_strb, input logic [31:0] exp_load,
                          input logic exp_err, input int exp_stall);
        exp_t e, got;
        int   stalls = 0;
        int   reqs   = 0;
        bit   seen_done  = 0;
        bit   ready_sent = 0;
        e.load  = exp_err ? 32'h0 : (rd ? exp_load : last_load);
        e.err   = exp_err;
        e.stall = exp_stall;
        last_load = e.load;
        sb.push_back(e);

        @(posedge clk); #1;
        mem_read_mem       = rd;
        mem_write_mem      = wr;
        alu_result_mem     = addr;
        rs2_data_mem       = rs2;
        mem_load_type_mem  = lt;
        mem_store_type_mem = st;

        for (int i = 0; i < 30 && !seen_done; i++) begin
            @(negedge clk);
            bus_ready     = 1'b0;
            bus_rsp_valid = 1'b0;
            if (done) begin
                seen_done = 1;
                got = sb.pop_front();
                chk({tag, "_load_data"}, load_data, got.load);
                chk({tag, "_bus_err"}, {31'h0, bus_err}, {31'h0, got.err});
                chk({tag, "_stall_cycles"}, stalls, got.stall);
                chk({tag, "_stall_in_done"}, {31'h0, stall_mem}, 32'h0);
            end else begin
                if (stall_mem) stalls++;
                if (bus_req) begin
                    reqs++;
                    chk({tag, "_bus_addr"}, bus_addr, exp_addr);
                    chk({tag, "_bus_we"}, {31'h0, bus_we}, {31'h0, wr});
                    chk({tag, "_bus_wstrb"}, {28'h0, bus_wstrb}, {28'h0, exp_strb});
                    if (wr) chk({tag, "_bus_wdata"}, bus_wdata, exp_wdata);
                    if (reqs == rdy_dly + 1) begin
                        bus_ready  = 1'b1;
                        ready_sent = 1;
                        if (early) begin
                            bus_rsp_valid = 1'b1;
                            bus_rdata     = 32'h5555_5555;
                        end
                    end
                end else if (ready_sent) begin
                    bus_rsp_valid = 1'b1;
                    bus_rdata     = rdata;
                end
            end
        end
        chk({tag, "_done_seen"}, {31'h0, seen_done}, 32'h1);

        @(posedge clk); #1;
        clear_inputs();
        bus_ready     = 1'b0;
        bus_rsp_valid = 1'b0;
        @(negedge clk);
        chk({tag, "_done_pulse"}, {31'h0, done}, 32'h0);
        chk({tag, "_idle_stall"}, {31'h0, stall_mem}, 32'h0);
    endtask

    task automatic misalign(input string tag, input logic rd, input logic [31:0] addr,
                            input logic [2:0] lt, input logic [1:0] st);
        @(posedge clk); #1;
        mem_read_mem       = rd;
        mem_write_mem      = !rd;
        alu_result_mem     = addr;
        rs2_data_mem       = 32'hFFFF_FFFF;
        mem_load_type_mem  = lt;
        mem_store_type_mem = st;
        @(negedge clk);
        chk({tag, "_exc"},   {31'h0, misalign_exc}, 32'h1);
        chk({tag, "_stall"}, {31'h0, stall_mem},    32'h0);
        chk({tag, "_req"},   {31'h0, bus_req},      32'h0);
        @(posedge clk); #1;
        clear_inputs();
        @(negedge clk);
        chk({tag, "_exc_pulse"}, {31'h0, misalign_exc}, 32'h0);
        chk({tag, "_no_req"},    {31'h0, bus_req},      32'h0);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus_ready     = 1'b0;
        bus_rsp_valid = 1'b0;
        bus_rdata     = 32'h0;
        clear_inputs();
        @(negedge clk);
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        //      tag      rd wr addr           rs2            lt      st     dly early rdata          exp_addr       exp_wdata      strb     exp_load       err  stall
        access("lw",     1, 0, 32'h0000_0100, 32'h0,         3'b010, 2'b11, 0, 0, 32'hDEAD_BEEF, 32'h0000_0100, 32'h0,         4'b0000, 32'hDEAD_BEEF, 0, 3);
        access("lb",     1, 0, 32'h0000_0103, 32'h0,         3'b000, 2'b11, 0, 0, 32'h80FF_0000, 32'h0000_0100, 32'h0,         4'b0000, 32'hFFFF_FF80, 0, 3);
        access("lbu",    1, 0, 32'h0000_0103, 32'h0,         3'b100, 2'b11, 1, 0, 32'h80FF_0000, 32'h0000_0100, 32'h0,         4'b0000, 32'h0000_0080, 0, 4);
        access("sh",     0, 1, 32'h0000_0202, 32'h1234_ABCD, 3'b111, 2'b01, 0, 0, 32'h0,         32'h0000_0200, 32'hABCD_ABCD, 4'b1100, 32'h0,         0, 3);
        access("sb",     0, 1, 32'h0000_0001, 32'h0000_005A, 3'b111, 2'b00, 1, 0, 32'h0,         32'h0000_0000, 32'h5A5A_5A5A, 4'b0010, 32'h0,         0, 4);
        access("lh",     1, 0, 32'h0000_0102, 32'h0,         3'b001, 2'b11, 0, 0, 32'h8001_1234, 32'h0000_0100, 32'h0,         4'b0000, 32'hFFFF_8001, 0, 3);
        access("lhu",    1, 0, 32'h0000_0100, 32'h0,         3'b101, 2'b11, 0, 0, 32'h8001_1234, 32'h0000_0100, 32'h0,         4'b0000, 32'h0000_1234, 0, 3);
        access("sw",     0, 1, 32'h0000_0300, 32'hCAFE_F00D, 3'b111, 2'b10, 0, 0, 32'h0,         32'h0000_0300, 32'hCAFE_F00D, 4'b1111, 32'h0,         0, 3);

        misalign("mis_lw", 1, 32'h0000_0101, 3'b010, 2'b11);
        misalign("mis_lh", 1, 32'h0000_0203, 3'b001, 2'b11);
        misalign("mis_sh", 0, 32'h0000_0001, 3'b111, 2'b01);

        // Ready never given: four REQ cycles then abort with load_data cleared.
        access("tmo",    1, 0, 32'h0000_0400, 32'h0,         3'b010, 2'b11, 100, 0, 32'h0,       32'h0000_0400, 32'h0,         4'b0000, 32'h0,         1, 5);
        // A late response while idle must be ignored.
        bus_rsp_valid = 1'b1;
        bus_rdata     = 32'hA5A5_A5A5;
        @(negedge clk);
        bus_rsp_valid = 1'b0;
        chk("late_rsp_done", {31'h0, done}, 32'h0);
        chk("late_rsp_load", load_data, 32'h0);

        // Response asserted together with ready in REQ is not taken; the WAIT one is.
        access("early",  1, 0, 32'h0000_0104, 32'h0,         3'b010, 2'b11, 0, 1, 32'h2222_2222, 32'h0000_0104, 32'h0,         4'b0000, 32'h2222_2222, 0, 3);

        // Reset pulled in WAIT with the load still held in EX/MEM.
        @(posedge clk); #1;
        mem_read_mem      = 1'b1;
        alu_result_mem    = 32'h0000_0500;
        mem_load_type_mem = 3'b010;
        @(negedge clk);                        // IDLE
        @(negedge clk);                        // REQ
        chk("rst_req", {31'h0, bus_req}, 32'h1);
        bus_ready = 1'b1;
        @(negedge clk);                        // WAIT
        bus_ready = 1'b0;
        chk("rst_wait_stall", {31'h0, stall_mem}, 32'h1);
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_wait");
        @(negedge clk);
        clear_inputs();
        rst_n = 1'b1;
        last_load = 32'h0;
        access("post_rst", 1, 0, 32'h0000_0600, 32'h0,       3'b010, 2'b11, 0, 0, 32'h0BAD_F00D, 32'h0000_0600, 32'h0,         4'b0000, 32'h0BAD_F00D, 0, 3);

        chk("sb_empty", sb.size(), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
